// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock user-interface sequencer.
package clock_pkg;

    localparam int COUNT_W = 6;

    // Button indices inside the packed press/raw vectors.
    localparam int BTN_MODE  = 0;
    localparam int BTN_SET   = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int BTN_START = 5;
    localparam int BTN_NUM   = 6;

    typedef enum logic [2:0] {
        ST_CLK_RUN  = 3'd0,
        ST_CLK_SET  = 3'd1,
        ST_TMR_IDLE = 3'd2,
        ST_TMR_SET  = 3'd3,
        ST_TMR_RUN  = 3'd4,
        ST_TMR_DONE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_e;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_MODE  = 3'd1,
        EV_SET   = 3'd2,
        EV_START = 3'd3,
        EV_SEL   = 3'd4,
        EV_UP    = 3'd5,
        EV_DOWN  = 3'd6
    } event_e;

    // Edit field rotation HOUR -> MIN -> SEC -> HOUR.
    function automatic field_e next_field(input field_e f);
        field_e r;
        case (f)
            FLD_HOUR: r = FLD_MIN;
            FLD_MIN:  r = FLD_SEC;
            default:  r = FLD_HOUR;
        endcase
        return r;
    endfunction

    // Only one press is consumed per cycle; lower-priority ones are dropped.
    function automatic event_e pick_event(input logic [BTN_NUM-1:0] p);
        event_e e;
        if (p[BTN_MODE]) begin
            e = EV_MODE;
        end else if (p[BTN_SET]) begin
            e = EV_SET;
        end else if (p[BTN_START]) begin
            e = EV_START;
        end else if (p[BTN_SEL]) begin
            e = EV_SEL;
        end else if (p[BTN_UP]) begin
            e = EV_UP;
        end else if (p[BTN_DOWN]) begin
            e = EV_DOWN;
        end else begin
            e = EV_NONE;
        end
        return e;
    endfunction

    function automatic logic is_clock_state(input state_e s);
        return (s == ST_CLK_RUN) || (s == ST_CLK_SET);
    endfunction

    function automatic logic is_set_state(input state_e s);
        return (s == ST_CLK_SET) || (s == ST_TMR_SET);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, stable-level debounce, rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic             differ_s;
    logic             cnt_done_s;

    assign differ_s   = sync_r ^ stable_r;
    assign cnt_done_s = (cnt_r == CNT_LAST);
    assign o_press    = press_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= i_btn;
            sync_r <= meta_r;
        end
    end

    // Count cycles the new level holds; any return to the old level restarts the count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end else if (differ_s && cnt_done_s) begin
            stable_r <= sync_r;
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= sync_r;
        end else if (differ_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            press_r  <= 1'b0;
        end else begin
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode sequencer for the digital clock / countdown timer.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int ALARM_CYCLES    = 5000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn_mode,
    input  logic               i_btn_set,
    input  logic               i_btn_sel,
    input  logic               i_btn_up,
    input  logic               i_btn_down,
    input  logic               i_btn_start,
    input  logic [COUNT_W-1:0] i_count_h,
    input  logic [COUNT_W-1:0] i_count_m,
    input  logic [COUNT_W-1:0] i_count_s,
    output logic               o_mode,
    output logic               o_set,
    output logic               o_hour,
    output logic               o_min,
    output logic               o_sec,
    output logic               o_up,
    output logic               o_down,
    output logic               o_start,
    output logic               o_resave,
    output logic               o_alarm
);

    localparam int ACNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_CYCLES - 1);

    logic [BTN_NUM-1:0] btn_raw_s;
    logic [BTN_NUM-1:0] press_s;
    event_e             ev_s;
    logic               any_press_s;
    logic               cnt_zero_s;

    state_e             state_r;
    field_e             field_r;
    logic [ACNT_W-1:0]  alarm_cnt_r;
    logic               mode_r;
    logic               set_r;
    logic               hour_r;
    logic               min_r;
    logic               sec_r;
    logic               up_r;
    logic               down_r;
    logic               start_r;
    logic               resave_r;
    logic               alarm_r;

    state_e             nxt_state_s;
    field_e             nxt_field_s;
    logic               nxt_up_s;
    logic               nxt_down_s;
    logic               nxt_resave_s;
    logic               nxt_set_s;

    assign btn_raw_s[BTN_MODE]  = i_btn_mode;
    assign btn_raw_s[BTN_SET]   = i_btn_set;
    assign btn_raw_s[BTN_SEL]   = i_btn_sel;
    assign btn_raw_s[BTN_UP]    = i_btn_up;
    assign btn_raw_s[BTN_DOWN]  = i_btn_down;
    assign btn_raw_s[BTN_START] = i_btn_start;

    for (genvar g = 0; g < BTN_NUM; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_btn   (btn_raw_s[g]),
            .o_press (press_s[g])
        );
    end

    assign ev_s        = pick_event(press_s);
    assign any_press_s = |press_s;
    assign cnt_zero_s  = (i_count_h == {COUNT_W{1'b0}}) &&
                         (i_count_m == {COUNT_W{1'b0}}) &&
                         (i_count_s == {COUNT_W{1'b0}});
    assign nxt_set_s   = is_set_state(nxt_state_s);

    // Next state, edit field and one-cycle strobes from the consumed event.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_field_s  = field_r;
        nxt_up_s     = 1'b0;
        nxt_down_s   = 1'b0;
        nxt_resave_s = 1'b0;
        case (state_r)
            ST_CLK_RUN: begin
                case (ev_s)
                    EV_MODE: begin
                        nxt_state_s  = ST_TMR_IDLE;
                        nxt_resave_s = 1'b1;
                    end
                    EV_SET: begin
                        nxt_state_s = ST_CLK_SET;
                        nxt_field_s = FLD_HOUR;
                    end
                    default: nxt_state_s = state_r;
                endcase
            end
            ST_CLK_SET, ST_TMR_SET: begin
                case (ev_s)
                    EV_SET: begin
                        if (state_r == ST_CLK_SET) begin
                            nxt_state_s = ST_CLK_RUN;
                        end else begin
                            nxt_state_s = ST_TMR_IDLE;
                        end
                    end
                    EV_SEL:  nxt_field_s = next_field(field_r);
                    // The counter edge-detects these, so never drive them in adjacent cycles.
                    EV_UP:   nxt_up_s    = ~up_r;
                    EV_DOWN: nxt_down_s  = ~down_r;
                    default: nxt_state_s = state_r;
                endcase
            end
            ST_TMR_IDLE: begin
                case (ev_s)
                    EV_SET: begin
                        nxt_state_s = ST_TMR_SET;
                        nxt_field_s = FLD_HOUR;
                    end
                    EV_START: begin
                        if (!cnt_zero_s) begin
                            nxt_state_s = ST_TMR_RUN;
                        end else begin
                            nxt_state_s = state_r;
                        end
                    end
                    EV_MODE: begin
                        nxt_state_s  = ST_CLK_RUN;
                        nxt_resave_s = 1'b1;
                    end
                    default: nxt_state_s = state_r;
                endcase
            end
            ST_TMR_RUN: begin
                if (cnt_zero_s) begin
                    nxt_state_s = ST_TMR_DONE;
                end else begin
                    case (ev_s)
                        EV_START: nxt_state_s = ST_TMR_IDLE;
                        EV_MODE: begin
                            nxt_state_s  = ST_CLK_RUN;
                            nxt_resave_s = 1'b1;
                        end
                        default: nxt_state_s = state_r;
                    endcase
                end
            end
            ST_TMR_DONE: begin
                // Any press only silences the alarm.
                if (any_press_s || (alarm_cnt_r == ACNT_LAST)) begin
                    nxt_state_s = ST_TMR_IDLE;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            default: begin
                nxt_state_s = ST_CLK_RUN;
                nxt_field_s = FLD_HOUR;
            end
        endcase
    end

    // State register with outputs decoded from the next state so both change together.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r  <= ST_CLK_RUN;
            field_r  <= FLD_HOUR;
            mode_r   <= 1'b1;
            set_r    <= 1'b0;
            hour_r   <= 1'b0;
            min_r    <= 1'b0;
            sec_r    <= 1'b0;
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            start_r  <= 1'b0;
            resave_r <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            field_r  <= nxt_field_s;
            mode_r   <= is_clock_state(nxt_state_s);
            set_r    <= nxt_set_s;
            hour_r   <= nxt_set_s && (nxt_field_s == FLD_HOUR);
            min_r    <= nxt_set_s && (nxt_field_s == FLD_MIN);
            sec_r    <= nxt_set_s && (nxt_field_s == FLD_SEC);
            up_r     <= nxt_up_s;
            down_r   <= nxt_down_s;
            start_r  <= (nxt_state_s == ST_TMR_RUN);
            resave_r <= nxt_resave_s;
            alarm_r  <= (nxt_state_s == ST_TMR_DONE);
        end
    end

    // Alarm duration counter: zero on TMR_DONE entry, counting while it stays there.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            alarm_cnt_r <= {ACNT_W{1'b0}};
        end else if ((state_r == ST_TMR_DONE) && (nxt_state_s == ST_TMR_DONE)) begin
            alarm_cnt_r <= alarm_cnt_r + ACNT_W'(1);
        end else begin
            alarm_cnt_r <= {ACNT_W{1'b0}};
        end
    end

    assign o_mode   = mode_r;
    assign o_set    = set_r;
    assign o_hour   = hour_r;
    assign o_min    = min_r;
    assign o_sec    = sec_r;
    assign o_up     = up_r;
    assign o_down   = down_r;
    assign o_start  = start_r;
    assign o_resave = resave_r;
    assign o_alarm  = alarm_r;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl (DEBOUNCE_CYCLES=4, ALARM_CYCLES=16).
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn;      // 0 mode, 1 set, 2 sel, 3 up, 4 down, 5 start
    logic [5:0] cnt_h, cnt_m, cnt_s;
    logic o_mode, o_set, o_hour, o_min, o_sec, o_up, o_down, o_start, o_resave, o_alarm;
    logic [9:0] outv;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector order: mode set hour min sec up down start resave alarm
    localparam logic [9:0] V_RESET    = 10'b1000000000;
    localparam logic [9:0] V_TMR_IDLE = 10'b0000000000;
    localparam logic [9:0] V_SET_HOUR = 10'b1110000000;
    localparam logic [9:0] V_SET_SEC  = 10'b1100100000;
    localparam logic [9:0] V_TMR_RUN  = 10'b0000000100;

    assign outv = {o_mode, o_set, o_hour, o_min, o_sec, o_up, o_down, o_start, o_resave, o_alarm};

    clock_mode_ctrl #(.DEBOUNCE_CYCLES(4), .ALARM_CYCLES(16)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_btn_mode(btn[0]), .i_btn_set(btn[1]), .i_btn_sel(btn[2]),
        .i_btn_up(btn[3]), .i_btn_down(btn[4]), .i_btn_start(btn[5]),
        .i_count_h(cnt_h), .i_count_m(cnt_m), .i_count_s(cnt_s),
        .o_mode(o_mode), .o_set(o_set), .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
        .o_up(o_up), .o_down(o_down), .o_start(o_start), .o_resave(o_resave), .o_alarm(o_alarm)
    );

    always #5 clk = ~clk;

    // Pulse monitors sampled on the falling edge.
    int   up_hi = 0, up_b2b = 0, rs0 = 0, rs1 = 0, set_rise = 0;
    logic prev_up = 1'b0, prev_set = 1'b0;
    always @(negedge clk) begin
        if (o_up) up_hi <= up_hi + 1;
        if (o_up && prev_up) up_b2b <= up_b2b + 1;
        if (o_resave && !o_mode) rs0 <= rs0 + 1;
        if (o_resave && o_mode) rs1 <= rs1 + 1;
        if (o_set && !prev_set) set_rise <= set_rise + 1;
        prev_up  <= o_up;
        prev_set <= o_set;
    end

    task automatic press(input int b);
        @(negedge clk) btn[b] = 1'b1;
        repeat (12) @(negedge clk);
        btn[b] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 6'd0; cnt_h = 6'd0; cnt_m = 6'd0; cnt_s = 6'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outv !== V_RESET) begin
            n_err++; $display("FAIL reset_active: got %b expected %b", outv, V_RESET);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outv !== V_RESET) begin
                n_err++; $display("FAIL reset_idle cycle %0d: got %b expected %b", i, outv, V_RESET);
            end
        end
    endtask

    task automatic test_bounce_set_edit();
        int s0, u0;
        s0 = set_rise;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) btn[1] = ~btn[1];
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        btn[1] = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (set_rise - s0 !== 1) begin
            n_err++; $display("FAIL bounce_set_entries: got %0d expected 1", set_rise - s0);
        end
        n_cmp++;
        if (outv !== V_SET_HOUR) begin
            n_err++; $display("FAIL set_hour: got %b expected %b", outv, V_SET_HOUR);
        end
        press(2); press(2);
        n_cmp++;
        if (outv !== V_SET_SEC) begin
            n_err++; $display("FAIL sel_to_sec: got %b expected %b", outv, V_SET_SEC);
        end
        u0 = up_hi;
        press(3); press(3); press(3);
        n_cmp++;
        if (up_hi - u0 !== 3) begin
            n_err++; $display("FAIL up_pulses: got %0d expected 3", up_hi - u0);
        end
        n_cmp++;
        if (up_b2b !== 0) begin
            n_err++; $display("FAIL up_back_to_back: got %0d expected 0", up_b2b);
        end
        press(1);
        n_cmp++;
        if (outv !== V_RESET) begin
            n_err++; $display("FAIL set_exit: got %b expected %b", outv, V_RESET);
        end
    endtask

    task automatic test_save_restore();
        int a0, a1;
        a0 = rs0; a1 = rs1;
        press(0);
        n_cmp++;
        if ((rs0 - a0 !== 1) || (rs1 !== a1)) begin
            n_err++; $display("FAIL save_strobe: got m0=%0d m1=%0d expected 1 0", rs0 - a0, rs1 - a1);
        end
        n_cmp++;
        if (outv !== V_TMR_IDLE) begin
            n_err++; $display("FAIL to_timer: got %b expected %b", outv, V_TMR_IDLE);
        end
        a0 = rs0;
        press(0);
        n_cmp++;
        if ((rs1 - a1 !== 1) || (rs0 !== a0)) begin
            n_err++; $display("FAIL restore_strobe: got m0=%0d m1=%0d expected 0 1", rs0 - a0, rs1 - a1);
        end
        n_cmp++;
        if (outv !== V_RESET) begin
            n_err++; $display("FAIL to_clock: got %b expected %b", outv, V_RESET);
        end
    endtask

    task automatic test_timer_start();
        press(0);
        press(5);
        n_cmp++;
        if (outv !== V_TMR_IDLE) begin
            n_err++; $display("FAIL start_zero: got %b expected %b", outv, V_TMR_IDLE);
        end
        cnt_s = 6'd2;
        press(5);
        n_cmp++;
        if (outv !== V_TMR_RUN) begin
            n_err++; $display("FAIL start_run: got %b expected %b", outv, V_TMR_RUN);
        end
    endtask

    task automatic test_expiry();
        int n;
        @(negedge clk) cnt_s = 6'd0;
        @(posedge clk); #1;
        n_cmp++;
        if ({o_start, o_alarm} !== 2'b01) begin
            n_err++; $display("FAIL expiry_edge: got %b expected 01", {o_start, o_alarm});
        end
        n = 0;
        @(negedge clk);
        while (o_alarm === 1'b1 && n < 40) begin n++; @(negedge clk); end
        n_cmp++;
        if (n !== 16) begin
            n_err++; $display("FAIL alarm_length: got %0d expected 16", n);
        end
        n_cmp++;
        if (outv !== V_TMR_IDLE) begin
            n_err++; $display("FAIL alarm_timeout_idle: got %b expected %b", outv, V_TMR_IDLE);
        end
        cnt_s = 6'd2;
        press(5);
        @(negedge clk) begin cnt_s = 6'd0; btn[1] = 1'b1; end
        @(posedge clk); #1;
        n_cmp++;
        if (o_alarm !== 1'b1) begin
            n_err++; $display("FAIL early_alarm_on: got %b expected 1", o_alarm);
        end
        n = 0;
        @(negedge clk);
        while (o_alarm === 1'b1 && n < 40) begin n++; @(negedge clk); end
        btn[1] = 1'b0;
        n_cmp++;
        if (n !== 6) begin
            n_err++; $display("FAIL early_clear_length: got %0d expected 6", n);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (outv !== V_TMR_IDLE) begin
            n_err++; $display("FAIL press_consumed: got %b expected %b", outv, V_TMR_IDLE);
        end
    endtask

    task automatic test_priority_and_reset();
        int u0, a0, a1;
        press(0);
        press(1);
        u0 = up_hi;
        @(negedge clk) begin btn[0] = 1'b1; btn[3] = 1'b1; end
        repeat (12) @(negedge clk);
        btn[0] = 1'b0; btn[3] = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (up_hi !== u0) begin
            n_err++; $display("FAIL up_dropped: got %0d pulses expected 0", up_hi - u0);
        end
        n_cmp++;
        if (outv !== V_SET_HOUR) begin
            n_err++; $display("FAIL mode_ignored_in_set: got %b expected %b", outv, V_SET_HOUR);
        end
        press(1); press(0);
        cnt_s = 6'd2;
        press(5);
        n_cmp++;
        if (outv !== V_TMR_RUN) begin
            n_err++; $display("FAIL run_before_reset: got %b expected %b", outv, V_TMR_RUN);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outv !== V_RESET) begin
            n_err++; $display("FAIL async_reset: got %b expected %b", outv, V_RESET);
        end
        repeat (3) @(negedge clk);
        a0 = rs0; a1 = rs1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ((rs0 !== a0) || (rs1 !== a1) || (outv !== V_RESET)) begin
            n_err++; $display("FAIL reset_release: got %b strobes %0d/%0d expected %b none",
                              outv, rs0 - a0, rs1 - a1, V_RESET);
        end
    endtask

    initial begin
        test_reset();
        test_bounce_set_edit();
        test_save_restore();
        test_timer_start();
        test_expiry();
        test_priority_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
